// File: rtl/data_memory_responder_pkg.sv
// data_memory_pkg: region decode constants and MMIO register offsets
package data_memory_pkg;
  localparam logic [3:0]  RAM_BASE  = 4'h0;
  localparam logic [27:0] MMIO_BASE = 28'h8000_000;
  typedef enum logic [1:0] {
    CONSOLE_DATA = 2'd0,
    CONSOLE_STAT = 2'd1,
    CYCLE_COUNT  = 2'd2,
    LEDS         = 2'd3
  } mmio_off_e;
endpackage

// File: rtl/data_memory_responder_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers; push while full is accepted only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic w_do_push, w_do_pop;
  assign o_count   = r_wr - r_rd;
  assign o_empty   = r_wr == r_rd;
  assign o_full    = o_count == (AW+1)'(DEPTH);
  assign o_data    = r_mem[r_rd[AW-1:0]];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr[AW-1:0]] <= i_data;
        r_wr <= r_wr + (AW+1)'(1);
      end
      if (w_do_pop) r_rd <= r_rd + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: word RAM plus MMIO console FIFO, cycle counter and LED register
module data_memory_responder
  import data_memory_pkg::*;
#(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8,
  parameter int LED_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          i_addr,
  input  logic                 i_write_enable,
  input  logic [31:0]          i_write_data,
  output logic [31:0]          o_read_data,
  output logic [7:0]           o_console_data,
  output logic                 o_console_valid,
  input  logic                 i_console_ready,
  output logic [LED_WIDTH-1:0] o_leds
);
  localparam int RAW = $clog2(RAM_WORDS);
  localparam int FAW = $clog2(FIFO_DEPTH);
  logic [31:0] r_ram [RAM_WORDS];
  logic [31:0] r_cycle;
  logic [LED_WIDTH-1:0] r_leds;
  logic r_overflow;
  logic w_is_ram, w_is_mmio, w_full, w_empty, w_push, w_unused;
  logic [RAW-1:0] w_ram_idx;
  logic [FAW:0] w_count;
  logic [31:0] w_stat, w_mmio_rd;
  mmio_off_e w_off;
  assign w_unused  = &{1'b0, i_addr[1:0]};
  assign w_is_ram  = i_addr[31:28] == RAM_BASE;
  assign w_is_mmio = i_addr[31:4] == MMIO_BASE;
  assign w_off     = mmio_off_e'(i_addr[3:2]);
  assign w_ram_idx = i_addr[RAW+1:2];
  assign w_push    = i_write_enable && w_is_mmio && w_off == CONSOLE_DATA;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (i_console_ready),
    .i_data  (i_write_data[7:0]),
    .o_data  (o_console_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
  assign o_console_valid = !w_empty;
  assign o_leds          = r_leds;
  assign w_stat    = {16'b0, 8'(w_count), 5'b0, r_overflow, w_empty, w_full};
  assign w_mmio_rd = (w_off == CONSOLE_STAT) ? w_stat :
                     (w_off == CYCLE_COUNT)  ? r_cycle :
                     (w_off == LEDS)         ? 32'(r_leds) : 32'b0;
  assign o_read_data = w_is_ram ? r_ram[w_ram_idx] : w_is_mmio ? w_mmio_rd : 32'b0;
  always_ff @(posedge clk) begin
    if (i_write_enable && w_is_ram) r_ram[w_ram_idx] <= i_write_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle    <= '0;
      r_leds     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_cycle <= (i_write_enable && w_is_mmio && w_off == CYCLE_COUNT) ? i_write_data : r_cycle + 32'd1;
      if (i_write_enable && w_is_mmio && w_off == LEDS) r_leds <= i_write_data[LED_WIDTH-1:0];
      // a full FIFO only drops the byte when the sink is not popping this cycle
      if (i_write_enable && w_is_mmio && w_off == CONSOLE_STAT) r_overflow <= 1'b0;
      else if (w_push && w_full && !i_console_ready) r_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed checks of RAM, console FIFO, cycle counter, LEDs and decode
module tb_data_memory_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] addr = '0;
  logic we = 1'b0;
  logic [31:0] wd = '0;
  logic [31:0] rdata;
  logic [7:0] cdata;
  logic cvalid;
  logic cready = 1'b0;
  logic [7:0] leds;
  int n_tests = 0;
  int n_fail = 0;

  data_memory_responder dut (
    .clk             (clk),
    .rst             (rst),
    .i_addr          (addr),
    .i_write_enable  (we),
    .i_write_data    (wd),
    .o_read_data     (rdata),
    .o_console_data  (cdata),
    .o_console_valid (cvalid),
    .i_console_ready (cready),
    .o_leds          (leds)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wd = d;
    we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic load_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  logic [7:0] exp3 [8] = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h5A};

  initial begin
    step();
    step();
    check("reset_valid", {31'b0, cvalid}, 32'h0);
    check("reset_leds", {24'b0, leds}, 32'h0);
    load_check("reset_stat", 32'h8000_0004, 32'h0000_0002);
    load_check("reset_counter", 32'h8000_0008, 32'h0);
    rst = 1'b0;

    // 1: RAM store/load, alias, old value during write
    store(32'h0000_0010, 32'hDEAD_BEEF);
    load_check("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
    load_check("ram_alias", 32'h0000_1010, 32'hDEAD_BEEF);
    addr = 32'h0000_0010; wd = 32'h1111_1111; we = 1'b1;
    #1;
    check("ram_rd_old", rdata, 32'hDEAD_BEEF);
    step();
    we = 1'b0;
    load_check("ram_rd_new", 32'h0000_0010, 32'h1111_1111);
    store(32'h0000_0010, 32'hDEAD_BEEF);
    load_check("ram_restore", 32'h0000_0010, 32'hDEAD_BEEF);

    // 2: overflow then ordered drain
    cready = 1'b0;
    for (int i = 0; i < 9; i++) store(32'h8000_0000, 32'h41 + i);
    load_check("stat_ovf", 32'h8000_0004, 32'h0000_0805);
    load_check("console_rd0", 32'h8000_0000, 32'h0);
    cready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", {31'b0, cvalid}, 32'h1);
      check("drain_data", {24'b0, cdata}, 32'h41 + i);
      step();
    end
    check("drain_done", {31'b0, cvalid}, 32'h0);
    cready = 1'b0;
    load_check("stat_empty_ovf", 32'h8000_0004, 32'h0000_0006);
    store(32'h8000_0004, 32'h0);
    load_check("stat_clr", 32'h8000_0004, 32'h0000_0002);

    // 3: push into full FIFO with simultaneous pop
    for (int i = 0; i < 8; i++) store(32'h8000_0000, 32'h50 + i);
    load_check("stat_full", 32'h8000_0004, 32'h0000_0801);
    cready = 1'b1;
    store(32'h8000_0000, 32'h5A);
    cready = 1'b0;
    load_check("stat_full_pop", 32'h8000_0004, 32'h0000_0801);
    cready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain3_data", {24'b0, cdata}, {24'b0, exp3[i]});
      step();
    end
    check("drain3_done", {31'b0, cvalid}, 32'h0);
    cready = 1'b0;

    // 4: counter load and wrap
    store(32'h8000_0008, 32'hFFFF_FFFE);
    load_check("cnt_load", 32'h8000_0008, 32'hFFFF_FFFE);
    step();
    check("cnt_max", rdata, 32'hFFFF_FFFF);
    step();
    check("cnt_wrap", rdata, 32'h0);

    // 5: LEDs and reset mid-traffic
    store(32'h8000_000C, 32'h1234_56A5);
    check("leds", {24'b0, leds}, 32'hA5);
    load_check("leds_rd", 32'h8000_000C, 32'h0000_00A5);
    store(32'h8000_0000, 32'h77);
    check("valid_pre_rst", {31'b0, cvalid}, 32'h1);
    cready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    cready = 1'b0;
    check("rst_leds", {24'b0, leds}, 32'h0);
    check("rst_valid", {31'b0, cvalid}, 32'h0);
    load_check("rst_counter", 32'h8000_0008, 32'h0);
    load_check("rst_stat", 32'h8000_0004, 32'h0000_0002);
    load_check("rst_ram", 32'h0000_0010, 32'hDEAD_BEEF);

    // 6: unmapped region
    store(32'h4000_0000, 32'h1234_5678);
    load_check("unmapped_rd", 32'h4000_0000, 32'h0);
    load_check("unmapped_ram", 32'h0000_0000 + 32'h10, 32'hDEAD_BEEF);
    load_check("unmapped_stat", 32'h8000_0004, 32'h0000_0002);
    check("unmapped_leds", {24'b0, leds}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
